// File: rtl/pc_stack_counter_if.sv
// pc_stack_counter_if: control inputs and PC/stack status outputs of the program counter
interface pc_stack_counter_if #(
    parameter int WIDTH = 5,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    logic             Clear;
    logic             Up;
    logic             Load;
    logic             Branch;
    logic             Call;
    logic             Ret;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] Offset;
    logic [WIDTH-1:0] O;
    logic [DW-1:0]    Depth;
    logic             Full;
    logic             Empty;
    logic             StackErr;
    modport master (
        output Clear, Up, Load, Branch, Call, Ret, Target, Offset,
        input  O, Depth, Full, Empty, StackErr
    );
    modport slave (
        input  Clear, Up, Load, Branch, Call, Ret, Target, Offset,
        output O, Depth, Full, Empty, StackErr
    );
endinterface

// File: rtl/pc_stack_counter.sv
// pc_stack_counter: program counter with jump, relative branch and a return-address stack
module pc_stack_counter #(
    parameter int WIDTH = 5,
    parameter int STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic Clock,
    input logic Reset_n,
    pc_stack_counter_if.slave bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);
    logic [WIDTH-1:0] pc, pc_next, top, ret_addr;
    logic [DW-1:0]    depth, depth_next;
    logic             err, err_next, push;
    logic [WIDTH-1:0] stack [STACK_DEPTH];
    assign ret_addr = pc + WIDTH'(1);
    // select the entry just below depth; falls back to pc when the stack is empty
    always_comb begin
        top = pc;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (DW'(i + 1) == depth) top = stack[i];
    end
    // one action per cycle in priority order Clear > Ret > Call > Load > Branch > Up
    always_comb begin
        pc_next = pc;
        depth_next = depth;
        err_next = err;
        push = 1'b0;
        if (bus.Clear) begin
            pc_next = RESET_VALUE;
            depth_next = '0;
            err_next = 1'b0;
        end else if (bus.Ret) begin
            if (depth == '0) begin
                err_next = 1'b1;
            end else begin
                pc_next = top;
                depth_next = depth - DW'(1);
            end
        end else if (bus.Call) begin
            if (depth == FULL_DEPTH) begin
                err_next = 1'b1;
            end else begin
                push = 1'b1;
                pc_next = bus.Target;
                depth_next = depth + DW'(1);
            end
        end else if (bus.Load) begin
            pc_next = bus.Target;
        end else if (bus.Branch) begin
            pc_next = pc + bus.Offset;
        end else if (bus.Up) begin
            pc_next = ret_addr;
        end
    end
    // architectural state; reset overrides every control input
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            pc <= RESET_VALUE;
            depth <= '0;
            err <= 1'b0;
        end else begin
            pc <= pc_next;
            depth <= depth_next;
            err <= err_next;
        end
    end
    // return-address storage; contents are don't-care after reset so it carries no reset
    always_ff @(posedge Clock) begin
        for (int i = 0; i < STACK_DEPTH; i++)
            if (push && Reset_n && DW'(i) == depth) stack[i] <= ret_addr;
    end
    assign bus.O = pc;
    assign bus.Depth = depth;
    assign bus.Full = depth == FULL_DEPTH;
    assign bus.Empty = depth == '0;
    assign bus.StackErr = err;
endmodule

// File: tb/tb_pc_stack_counter.sv
// tb_pc_stack_counter: directed test-plan steps plus random controls against a queue-based model
module tb_pc_stack_counter;
    localparam int W = 5;
    localparam int SD = 4;
    logic Clock = 1'b0;
    logic Reset_n = 1'b1;
    pc_stack_counter_if #(.WIDTH(W), .STACK_DEPTH(SD)) bus ();
    pc_stack_counter #(.WIDTH(W), .STACK_DEPTH(SD), .RESET_VALUE('0)) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .bus(bus)
    );
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int m_pc = 0;
    int m_err = 0;
    int m_stk[$];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: return stack as a queue, PC as modular integer arithmetic
    always @(posedge Clock) begin
        if (!Reset_n || bus.Clear) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 0;
        end else if (bus.Ret) begin
            if (m_stk.size() == 0) m_err = 1;
            else m_pc = m_stk.pop_back();
        end else if (bus.Call) begin
            if (m_stk.size() == SD) m_err = 1;
            else begin
                m_stk.push_back((m_pc + 1) % 32);
                m_pc = int'(bus.Target);
            end
        end else if (bus.Load) m_pc = int'(bus.Target);
        else if (bus.Branch) m_pc = (m_pc + int'($signed(bus.Offset))) & 31;
        else if (bus.Up) m_pc = (m_pc + 1) & 31;
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge Clock) begin
        if (chk_en) begin
            check("O", int'(bus.O), m_pc);
            check("Depth", int'(bus.Depth), m_stk.size());
            check("Full", int'(bus.Full), int'(m_stk.size() == SD));
            check("Empty", int'(bus.Empty), int'(m_stk.size() == 0));
            check("StackErr", int'(bus.StackErr), m_err);
        end
    end

    task automatic cyc(input logic rn, clr, up, ld, br, cl, rt, input logic [W-1:0] tgt, off);
        Reset_n = rn;
        bus.Clear = clr;
        bus.Up = up;
        bus.Load = ld;
        bus.Branch = br;
        bus.Call = cl;
        bus.Ret = rt;
        bus.Target = tgt;
        bus.Offset = off;
        @(posedge Clock);
        @(negedge Clock);
        #1;
    endtask

    task automatic lit(input string nm, input int o, input int d, input int e);
        check({nm, ".O"}, int'(bus.O), o);
        check({nm, ".Depth"}, int'(bus.Depth), d);
        check({nm, ".StackErr"}, int'(bus.StackErr), e);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // 1: reset beats Up and Call, then count through the wrap
        cyc(0, 0, 1, 0, 0, 1, 0, 9, 0);
        chk_en = 1'b1;
        lit("reset", 0, 0, 0);
        check("reset.Empty", int'(bus.Empty), 1);
        for (int i = 0; i < 33; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
            if (i == 30) check("up31", int'(bus.O), 31);
            if (i == 31) check("wrap0", int'(bus.O), 0);
            if (i == 32) check("wrap1", int'(bus.O), 1);
        end
        // 2: branch both directions and absolute load
        cyc(1, 0, 0, 1, 0, 0, 0, 3, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 5'b11110);
        lit("br_neg", 1, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 30, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 5);
        lit("br_wrap", 3, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 17, 0);
        lit("load", 17, 0, 0);
        // 3: nested call / return
        cyc(1, 0, 0, 1, 0, 0, 0, 4, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 10, 0);
        lit("call1", 10, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 20, 0);
        lit("call2", 20, 2, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("ret1", 11, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("ret2", 5, 0, 0);
        check("ret2.Empty", int'(bus.Empty), 1);
        // 4: fill, overflow, LIFO drain, underflow, clear
        for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 0, 0, 1, 0, W'(i), 0);
        check("fill.Full", int'(bus.Full), 1);
        cyc(1, 0, 0, 0, 0, 1, 0, 9, 0);
        lit("ovf", 4, 4, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("pop4", 4, 3, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("pop3", 3, 2, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("pop2", 2, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("pop1", 6, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("udf", 6, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        lit("clear", 0, 0, 0);
        // 5: simultaneous controls
        cyc(1, 0, 0, 1, 0, 0, 0, 7, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 2, 0);
        lit("up_ld", 2, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 11, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 30, 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 5, 0);
        lit("call_ret", 12, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 8, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 9, 0);
        lit("clr_call", 0, 0, 0);
        // 6: reset in the middle of a call chain
        for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 0, 0, 1, 0, W'(i), 0);
        check("mid.Depth", int'(bus.Depth), 3);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("mid_rst", 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        lit("post_udf", 0, 0, 1);
        // random controls; reset and clear are rare so the stack gets exercised
        for (int i = 0; i < 3000; i++)
            cyc(logic'($urandom_range(99) != 0), logic'($urandom_range(59) == 0),
                logic'($urandom_range(3) == 0), logic'($urandom_range(5) == 0),
                logic'($urandom_range(5) == 0), logic'($urandom_range(3) == 0),
                logic'($urandom_range(3) == 0), W'($urandom), W'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_stack_counter.md
Name: pc_stack_counter

Overview:
- Parametrised program counter for the Lab B datapath. It is the next generation of the 5-bit clear/increment PC.
- Adds a configurable address width, absolute jump, signed relative branch, and a hardware return-address stack for call/return.
- Feeds instruction-memory address directly. Control inputs come from the controller FSM; all updates occur on the rising edge of Clock.

Parameters:
WIDTH, 5, PC/address width in bits (>=2)
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_VALUE, 0, value loaded into O on reset or Clear (WIDTH bits)

Ports:
Clock  in  1  system clock; all state changes on posedge
Reset_n  in  1  synchronous active-low reset
Clear  in  1  synchronous clear: O<=RESET_VALUE, stack emptied, StackErr cleared
Up  in  1  increment PC by 1
Load  in  1  absolute jump: O<=Target
Target  in  WIDTH  jump/call destination
Branch  in  1  relative branch: O<=O+Offset
Offset  in  WIDTH  signed two's-complement branch offset
Call  in  1  push O+1 onto stack, O<=Target
Ret  in  1  pop stack top into O
O  out  WIDTH  current PC, registered
Depth  out  clog2(STACK_DEPTH+1)  number of valid stack entries, registered
Full  out  1  Depth==STACK_DEPTH (combinational from Depth)
Empty  out  1  Depth==0 (combinational from Depth)
StackErr  out  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (Reset_n=0 at posedge):
  - O<=RESET_VALUE, Depth<=0, StackErr<=0.
  - Stack contents are don't-care.
  - Overrides every other input, including mid-call/return.
- Priority at each posedge, highest first: Reset_n=0 > Clear > Ret > Call > Load > Branch > Up > hold.
  - Exactly one action is taken per cycle; lower-priority inputs asserted in the same cycle are ignored (no partial effect).
- Hold: no control asserted → O, Depth, StackErr unchanged.
- Up: O<=(O+1) mod 2^WIDTH. All-ones wraps to 0, no flag.
- Load: O<=Target.
- Branch: O<=(O+sign_extended(Offset)) mod 2^WIDTH. Offset is interpreted as a signed WIDTH-bit value; the result wraps both directions.
- Call, not full:
  - stack[Depth]<=(O+1) mod 2^WIDTH; Depth<=Depth+1; O<=Target.
- Call, Full=1 (overflow):
  - No push, Depth unchanged, O unchanged, StackErr<=1.
- Ret, not empty:
  - O<=stack[Depth-1]; Depth<=Depth-1.
- Ret, Empty=1 (underflow):
  - O unchanged, Depth unchanged, StackErr<=1.
- Clear: same effect as reset except it is qualified by Reset_n=1. StackErr<=0.
- StackErr is sticky. Only Reset_n=0 or Clear clears it. It does not block further operations.
- Latency: one cycle. O reflects the action on the posedge where the controls are sampled. No combinational path from inputs to O or Depth.
- Stack is LIFO. Storage is registers; no memory inference is required. Entries above Depth are never read.
- Full and Empty are purely decoded from registered Depth, so they are glitch-free relative to Clock.

Test Plan (WIDTH=5, STACK_DEPTH=4, RESET_VALUE=0):
1. Reset_n=0 one cycle with Up=1, Call=1 → O=0, Depth=0, Empty=1, StackErr=0. Then Up=1 for 33 cycles → O counts 1..31, 0, 1 (wrap at 31→0).
2. O=3, Branch=1, Offset=5'b11110 (-2) → O=1. O=30, Branch=1, Offset=5 → O=3 (wrap). Load=1, Target=17 → O=17.
3. O=4, Call with Target=10 → O=10, Depth=1. Call with Target=20 → O=20, Depth=2. Ret → O=11, Depth=1. Ret → O=5, Depth=0, Empty=1.
4. Four Calls fill the stack → Full=1. A fifth Call, Target=9 → O unchanged, Depth=4, StackErr=1. Four Rets return in LIFO order. A fifth Ret → O unchanged, StackErr stays 1. Clear → O=0, Depth=0, StackErr=0.
5. Simultaneous inputs: O=7 with Up=1, Load=1, Target=2 → O=2. Call=1 and Ret=1 with Depth=1, top=12 → O=12, Depth=0, no push. Clear=1 and Call=1 → O=0, Depth=0.
6. Reset mid-sequence: Depth=3, then Reset_n=0 with Ret=1 → O=0, Depth=0. The next Ret → underflow, StackErr=1, O=0.
